// File: rtl/transfer_sequencer_pkg.sv
// Shared definitions for the receive-then-forward sequencer: state codes,
// latched error codes and the packing of the display status word.
package transfer_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RECV  = 4'd1,
        ST_CHECK = 4'd2,
        ST_DRAIN = 4'd3,
        ST_DONE  = 4'd4,
        ST_FAULT = 4'd5
    } state_t;

    localparam logic [3:0] ERR_NONE         = 4'h0;
    localparam logic [3:0] ERR_OVERFLOW     = 4'hD;
    localparam logic [3:0] ERR_EARLY_FINISH = 4'hE;
    localparam logic [3:0] ERR_TIMEOUT      = 4'hF;

    function automatic logic [15:0] pack_status(input state_t st, input logic [3:0] err,
                                                input logic [7:0] crc);
        return {st, err, crc};
    endfunction

endpackage

// File: rtl/transfer_sequencer_edge_detect.sv
// Registered rising-edge detector: remembers last cycle's level so a level
// already high when first observed is not mistaken for a new edge.
module transfer_sequencer_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sig & ~prev_q;

endmodule

// File: rtl/transfer_sequencer.sv
// Start-triggered sequencer for COM_to_FIFO then FIFO_to_out, with a stall
// watchdog, error/CRC latching and a status word for the seven-segment display.
module transfer_sequencer
    import transfer_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int COUNT_W        = 10,
    parameter bit AUTO_RESTART   = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               com_finish,
    input  logic [3:0]         com_error,
    input  logic [7:0]         com_crc,
    input  logic               fifo_empty,
    input  logic               fifo_full,
    input  logic [COUNT_W-1:0] fifo_count,
    input  logic               out_finish,
    output logic               com_enable,
    output logic               out_enable,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [15:0]        status
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         err_q, err_d;
    logic [7:0]         crc_q, crc_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;

    logic com_rise;
    logic out_rise;
    logic watching;
    logic wd_expired;

    transfer_sequencer_edge_detect u_com_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (com_finish),
        .rise  (com_rise)
    );

    transfer_sequencer_edge_detect u_out_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (out_finish),
        .rise  (out_rise)
    );

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        crc_d      = crc_q;
        watching   = (state_q == ST_RECV) || (state_q == ST_DRAIN);
        wd_expired = watching && (wd_q == WD_LAST);

        // Within a state, earlier branches win: overflow, then stall, then finish edges.
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (fifo_full) begin
                    state_d = ST_FAULT;
                    err_d   = ERR_OVERFLOW;
                end else if (wd_expired) begin
                    state_d = ST_FAULT;
                    err_d   = ERR_TIMEOUT;
                end else if (com_rise) begin
                    state_d = ST_CHECK;
                    err_d   = com_error;
                    crc_d   = com_crc;
                end
            end
            ST_CHECK: begin
                if (err_q != ERR_NONE) begin
                    state_d = ST_FAULT;
                end else if (fifo_empty) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wd_expired) begin
                    state_d = ST_FAULT;
                    err_d   = ERR_TIMEOUT;
                end else if (out_rise) begin
                    if (fifo_empty) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FAULT;
                        err_d   = ERR_EARLY_FINISH;
                    end
                end
            end
            ST_DONE: begin
                if (AUTO_RESTART || start) begin
                    state_d = ST_RECV;
                end
            end
            ST_FAULT: begin
                if (start) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_NONE;
                    crc_d   = 8'h00;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
        cnt_d  = fifo_count;

        // Any state change or FIFO movement counts as progress and restarts the stall count.
        if (!watching || (state_d != state_q) || (fifo_count != cnt_q)) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
            crc_q   <= 8'h00;
            wd_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            crc_q   <= crc_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign com_enable = (state_q == ST_RECV);
    assign out_enable = (state_q == ST_DRAIN);
    assign busy       = (state_q == ST_RECV) || (state_q == ST_CHECK) || (state_q == ST_DRAIN);
    assign done       = done_q;
    assign fault      = (state_q == ST_FAULT);
    assign status     = pack_status(state_q, err_q, crc_q);

endmodule

// File: tb/tb_transfer_sequencer.sv
// Bench for transfer_sequencer: directed stimulus pushes expected output
// snapshots (with the cycle they must appear) and a monitor checks every change.
module tb_transfer_sequencer;
  import transfer_sequencer_pkg::*;

  localparam int T     = 16;
  localparam int VEC_W = 21;
  localparam int EXP_W = 32 + VEC_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic [31:0] cyc = 32'd0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // dut0: AUTO_RESTART=0, dut1: AUTO_RESTART=1
  logic       a_reset, a_start, a_com_finish, a_fifo_empty, a_fifo_full, a_out_finish;
  logic [3:0] a_com_error;
  logic [7:0] a_com_crc;
  logic [9:0] a_fifo_count;
  logic       a_com_enable, a_out_enable, a_busy, a_done, a_fault;
  logic [15:0] a_status;

  logic       b_reset, b_start, b_com_finish, b_fifo_empty, b_fifo_full, b_out_finish;
  logic [3:0] b_com_error;
  logic [7:0] b_com_crc;
  logic [9:0] b_fifo_count;
  logic       b_com_enable, b_out_enable, b_busy, b_done, b_fault;
  logic [15:0] b_status;

  transfer_sequencer #(.TIMEOUT_CYCLES(T), .COUNT_W(10), .AUTO_RESTART(1'b0)) dut0 (
    .clk(clk), .reset(a_reset), .start(a_start), .com_finish(a_com_finish),
    .com_error(a_com_error), .com_crc(a_com_crc), .fifo_empty(a_fifo_empty),
    .fifo_full(a_fifo_full), .fifo_count(a_fifo_count), .out_finish(a_out_finish),
    .com_enable(a_com_enable), .out_enable(a_out_enable), .busy(a_busy),
    .done(a_done), .fault(a_fault), .status(a_status)
  );

  transfer_sequencer #(.TIMEOUT_CYCLES(T), .COUNT_W(10), .AUTO_RESTART(1'b1)) dut1 (
    .clk(clk), .reset(b_reset), .start(b_start), .com_finish(b_com_finish),
    .com_error(b_com_error), .com_crc(b_com_crc), .fifo_empty(b_fifo_empty),
    .fifo_full(b_fifo_full), .fifo_count(b_fifo_count), .out_finish(b_out_finish),
    .com_enable(b_com_enable), .out_enable(b_out_enable), .busy(b_busy),
    .done(b_done), .fault(b_fault), .status(b_status)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q0[$];
  logic [EXP_W-1:0] exp_q1[$];
  int n_checks = 0;
  int n_errors = 0;

  // Expected output snapshot for a given state, derived from the state meaning.
  function automatic logic [VEC_W-1:0] mk(input logic [3:0] st, input logic [3:0] err,
                                           input logic [7:0] crc, input logic dn);
    logic ce, oe, bz, ft;
    ce = (st == 4'd1);
    oe = (st == 4'd3);
    bz = (st == 4'd1) || (st == 4'd2) || (st == 4'd3);
    ft = (st == 4'd5);
    return {st, err, crc, ce, oe, bz, dn, ft};
  endfunction

  task automatic ex0(input logic [3:0] st, input logic [3:0] err, input logic [7:0] crc,
                     input logic dn, input int at);
    exp_q0.push_back({32'(at), mk(st, err, crc, dn)});
  endtask

  task automatic ex1(input logic [3:0] st, input logic [3:0] err, input logic [7:0] crc,
                     input logic dn, input int at);
    exp_q1.push_back({32'(at), mk(st, err, crc, dn)});
  endtask

  // ---------------- monitor ----------------
  logic [VEC_W-1:0] obs0, obs1, last0, last1;
  logic seen0 = 1'b0;
  logic seen1 = 1'b0;
  logic [EXP_W-1:0] e0, e1;

  always @(negedge clk) begin
    obs0 = {a_status, a_com_enable, a_out_enable, a_busy, a_done, a_fault};
    obs1 = {b_status, b_com_enable, b_out_enable, b_busy, b_done, b_fault};
    if (!seen0 || obs0 != last0) begin
      seen0 = 1'b1;
      last0 = obs0;
      n_checks++;
      if (exp_q0.size() == 0) begin
        n_errors++;
        $display("FAIL dut0 unexpected_change: got vec=%h at cyc %0d, expected no change", obs0, cyc);
      end else begin
        e0 = exp_q0.pop_front();
        if (e0[VEC_W-1:0] !== obs0 || e0[EXP_W-1:VEC_W] != cyc) begin
          n_errors++;
          $display("FAIL dut0 step: got vec=%h at cyc %0d, expected vec=%h at cyc %0d",
                   obs0, cyc, e0[VEC_W-1:0], e0[EXP_W-1:VEC_W]);
        end
      end
    end
    if (!seen1 || obs1 != last1) begin
      seen1 = 1'b1;
      last1 = obs1;
      n_checks++;
      if (exp_q1.size() == 0) begin
        n_errors++;
        $display("FAIL dut1 unexpected_change: got vec=%h at cyc %0d, expected no change", obs1, cyc);
      end else begin
        e1 = exp_q1.pop_front();
        if (e1[VEC_W-1:0] !== obs1 || e1[EXP_W-1:VEC_W] != cyc) begin
          n_errors++;
          $display("FAIL dut1 step: got vec=%h at cyc %0d, expected vec=%h at cyc %0d",
                   obs1, cyc, e1[VEC_W-1:0], e1[EXP_W-1:VEC_W]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_cyc(input int n);
    while (cyc < 32'(n)) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    a_reset = 1'b1; a_start = 1'b0; a_com_finish = 1'b0; a_com_error = 4'h0; a_com_crc = 8'h00;
    a_fifo_empty = 1'b1; a_fifo_full = 1'b0; a_fifo_count = 10'd0; a_out_finish = 1'b0;
    b_reset = 1'b1; b_start = 1'b0; b_com_finish = 1'b0; b_com_error = 4'h0; b_com_crc = 8'h00;
    b_fifo_empty = 1'b1; b_fifo_full = 1'b0; b_fifo_count = 10'd0; b_out_finish = 1'b0;
    ex0(ST_IDLE, 4'h0, 8'h00, 1'b0, 1);
    ex1(ST_IDLE, 4'h0, 8'h00, 1'b0, 1);
    wait_cyc(2); a_reset = 1'b0; b_reset = 1'b0;

    // full pass: RECV -> CHECK -> DRAIN -> DONE, CRC A5 latched
    wait_cyc(3); a_start = 1'b1; ex0(ST_RECV, 4'h0, 8'h00, 1'b0, 4);
    wait_cyc(4); a_start = 1'b0; a_fifo_empty = 1'b0; a_fifo_count = 10'd3;
    wait_cyc(6); a_com_crc = 8'hA5; a_com_error = 4'h0; a_com_finish = 1'b1;
    ex0(ST_CHECK, 4'h0, 8'hA5, 1'b0, 7); ex0(ST_DRAIN, 4'h0, 8'hA5, 1'b0, 8);
    wait_cyc(8); a_com_finish = 1'b0;
    wait_cyc(10); a_fifo_empty = 1'b1; a_fifo_count = 10'd0; a_out_finish = 1'b1;
    ex0(ST_DONE, 4'h0, 8'hA5, 1'b1, 11); ex0(ST_DONE, 4'h0, 8'hA5, 1'b0, 12);
    wait_cyc(11); a_out_finish = 1'b0;

    // receive error code 2 -> FAULT, start clears to IDLE
    wait_cyc(13); a_start = 1'b1; ex0(ST_RECV, 4'h0, 8'hA5, 1'b0, 14);
    wait_cyc(14); a_start = 1'b0; a_fifo_empty = 1'b0; a_fifo_count = 10'd5;
    wait_cyc(15); a_com_error = 4'h2; a_com_crc = 8'h3C; a_com_finish = 1'b1;
    ex0(ST_CHECK, 4'h2, 8'h3C, 1'b0, 16); ex0(ST_FAULT, 4'h2, 8'h3C, 1'b0, 17);
    wait_cyc(16); a_com_finish = 1'b0; a_com_error = 4'h0;
    wait_cyc(18); a_start = 1'b1; ex0(ST_IDLE, 4'h0, 8'h00, 1'b0, 19);
    wait_cyc(19); a_start = 1'b0;

    // watchdog: count moves once (sampled at edge 25), then frozen T cycles
    wait_cyc(20); a_start = 1'b1; ex0(ST_RECV, 4'h0, 8'h00, 1'b0, 21);
    ex0(ST_FAULT, 4'hF, 8'h00, 1'b0, 25 + T);
    wait_cyc(21); a_start = 1'b0;
    wait_cyc(24); a_fifo_count = 10'd6;
    wait_cyc(28); a_start = 1'b1;
    wait_cyc(29); a_start = 1'b0;
    wait_cyc(26 + T); a_start = 1'b1; ex0(ST_IDLE, 4'h0, 8'h00, 1'b0, 27 + T);
    wait_cyc(27 + T); a_start = 1'b0;

    // overflow wins over a same-cycle com_finish edge
    wait_cyc(44); a_start = 1'b1; ex0(ST_RECV, 4'h0, 8'h00, 1'b0, 45);
    wait_cyc(45); a_start = 1'b0;
    wait_cyc(46); a_com_finish = 1'b1; a_fifo_full = 1'b1; a_com_crc = 8'h77;
    ex0(ST_FAULT, 4'hD, 8'h00, 1'b0, 47);
    wait_cyc(47); a_fifo_full = 1'b0; a_com_finish = 1'b0;
    wait_cyc(48); a_start = 1'b1; ex0(ST_IDLE, 4'h0, 8'h00, 1'b0, 49);
    wait_cyc(49); a_start = 1'b0;

    // reset in the middle of DRAIN
    wait_cyc(50); a_start = 1'b1; ex0(ST_RECV, 4'h0, 8'h00, 1'b0, 51);
    wait_cyc(51); a_start = 1'b0; a_fifo_count = 10'd4; a_com_crc = 8'h5A; a_com_finish = 1'b1;
    ex0(ST_CHECK, 4'h0, 8'h5A, 1'b0, 52); ex0(ST_DRAIN, 4'h0, 8'h5A, 1'b0, 53);
    wait_cyc(52); a_com_finish = 1'b0;
    wait_cyc(54); a_reset = 1'b1; ex0(ST_IDLE, 4'h0, 8'h00, 1'b0, 55);
    wait_cyc(55); a_reset = 1'b0;

    // out_finish while FIFO not empty -> FAULT E
    wait_cyc(56); a_start = 1'b1; ex0(ST_RECV, 4'h0, 8'h00, 1'b0, 57);
    wait_cyc(57); a_start = 1'b0; a_com_crc = 8'h11; a_com_finish = 1'b1;
    ex0(ST_CHECK, 4'h0, 8'h11, 1'b0, 58); ex0(ST_DRAIN, 4'h0, 8'h11, 1'b0, 59);
    wait_cyc(58); a_com_finish = 1'b0;
    wait_cyc(60); a_out_finish = 1'b1; ex0(ST_FAULT, 4'hE, 8'h11, 1'b0, 61);
    wait_cyc(61); a_out_finish = 1'b0;
    wait_cyc(62); a_start = 1'b1; ex0(ST_IDLE, 4'h0, 8'h00, 1'b0, 63);
    wait_cyc(63); a_start = 1'b0;

    // nothing to forward: CHECK goes straight to DONE
    wait_cyc(64); a_start = 1'b1; ex0(ST_RECV, 4'h0, 8'h00, 1'b0, 65);
    wait_cyc(65); a_start = 1'b0; a_fifo_empty = 1'b1; a_fifo_count = 10'd0;
    a_com_crc = 8'hC3; a_com_finish = 1'b1;
    ex0(ST_CHECK, 4'h0, 8'hC3, 1'b0, 66); ex0(ST_DONE, 4'h0, 8'hC3, 1'b1, 67);
    ex0(ST_DONE, 4'h0, 8'hC3, 1'b0, 68);
    wait_cyc(66); a_com_finish = 1'b0;

    // com_finish already high on RECV entry must wait for a low phase
    wait_cyc(69); a_com_finish = 1'b1;
    wait_cyc(70); a_start = 1'b1; ex0(ST_RECV, 4'h0, 8'hC3, 1'b0, 71);
    wait_cyc(71); a_start = 1'b0;
    wait_cyc(74); a_com_finish = 1'b0;
    wait_cyc(75); a_com_crc = 8'h2B; a_com_finish = 1'b1;
    ex0(ST_CHECK, 4'h0, 8'h2B, 1'b0, 76); ex0(ST_DONE, 4'h0, 8'h2B, 1'b1, 77);
    ex0(ST_DONE, 4'h0, 8'h2B, 1'b0, 78);
    wait_cyc(76); a_com_finish = 1'b0;

    // AUTO_RESTART: DONE -> RECV without start; held com_finish not re-accepted
    wait_cyc(80); b_start = 1'b1; ex1(ST_RECV, 4'h0, 8'h00, 1'b0, 81);
    wait_cyc(81); b_start = 1'b0; b_fifo_empty = 1'b0; b_fifo_count = 10'd2;
    wait_cyc(82); b_com_crc = 8'h9D; b_com_finish = 1'b1;
    ex1(ST_CHECK, 4'h0, 8'h9D, 1'b0, 83); ex1(ST_DRAIN, 4'h0, 8'h9D, 1'b0, 84);
    wait_cyc(85); b_out_finish = 1'b1; b_fifo_empty = 1'b1; b_fifo_count = 10'd0;
    ex1(ST_DONE, 4'h0, 8'h9D, 1'b1, 86); ex1(ST_RECV, 4'h0, 8'h9D, 1'b0, 87);
    wait_cyc(86); b_out_finish = 1'b0;
    wait_cyc(90); b_com_finish = 1'b0;
    wait_cyc(91); b_com_crc = 8'h42; b_com_finish = 1'b1;
    ex1(ST_CHECK, 4'h0, 8'h42, 1'b0, 92); ex1(ST_DONE, 4'h0, 8'h42, 1'b1, 93);
    ex1(ST_RECV, 4'h0, 8'h42, 1'b0, 94);
    wait_cyc(92); b_com_finish = 1'b0;
    wait_cyc(96); b_reset = 1'b1; ex1(ST_IDLE, 4'h0, 8'h00, 1'b0, 97);
    wait_cyc(97); b_reset = 1'b0;

    wait_cyc(100);
    @(negedge clk);
    #1;

    // ---------------- final report ----------------
    n_checks++;
    if (exp_q0.size() != 0) begin
      n_errors++;
      $display("FAIL dut0 missing: %0d expected changes never seen, first vec=%h at cyc %0d",
               exp_q0.size(), exp_q0[0][VEC_W-1:0], exp_q0[0][EXP_W-1:VEC_W]);
    end
    n_checks++;
    if (exp_q1.size() != 0) begin
      n_errors++;
      $display("FAIL dut1 missing: %0d expected changes never seen, first vec=%h at cyc %0d",
               exp_q1.size(), exp_q1[0][VEC_W-1:0], exp_q1[0][EXP_W-1:VEC_W]);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
